// File: rtl/signed_add_pkg.sv
// Shared types and default sizes for the shared signed add/subtract arbiter.
package signed_add_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 32;

endpackage

// File: rtl/signed_add_core.sv
// Combinational two's-complement add/subtract with signed-overflow detection.
module signed_add_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic             a_msb;
  logic             b_msb;
  logic             s_msb;

  // Subtraction is A + ~B + 1, so the carry-in is the sub flag itself.
  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};

  assign a_msb = a[WIDTH-1];
  assign b_msb = b[WIDTH-1];
  assign s_msb = sum[WIDTH-1];

  // Judged on the original B, so B = most-negative is handled for subtract.
  always_comb begin
    ovf = 1'b0;
    if (sub) begin
      ovf = (a_msb != b_msb) && (s_msb != a_msb);
    end else begin
      ovf = (a_msb == b_msb) && (s_msb != a_msb);
    end
  end

endmodule

// File: rtl/signed_add_arbiter.sv
// Round-robin arbiter sharing one signed add/subtract core between requesters,
// with a registered single-entry result stage.
module signed_add_arbiter
  import signed_add_pkg::*;
#(
  parameter int  NUM_REQ = NUM_REQ_DEF,
  parameter int  WIDTH   = WIDTH_DEF,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_ovf,
  output logic [ID_W-1:0]          rsp_id
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic             grant_any;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand_idx;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] core_sum;
  logic             core_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign a_arr[gi]     = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi]     = req_b[gi*WIDTH +: WIDTH];
      assign grant[gi]     = grant_any && (grant_idx == ID_W'(gi));
      assign req_ready[gi] = grant[gi] & can_accept;
    end
  endgenerate

  // First valid requester found walking upward from the one after rr_ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_idx = ID_W'((int'(rr_ptr_q) + off) % NUM_REQ);
      if (!grant_any && req_valid[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign can_accept = (state_q == IDLE) || rsp_ready;
  assign accept     = grant_any && can_accept;

  signed_add_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a   (a_arr[grant_idx]),
    .b   (b_arr[grant_idx]),
    .sub (req_sub[grant_idx]),
    .sum (core_sum),
    .ovf (core_ovf)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    id_d     = id_q;
    if (accept) begin
      state_d  = RESP;
      rr_ptr_d = grant_idx;
      sum_d    = core_sum;
      ovf_d    = core_ovf;
      id_d     = grant_idx;
    end else if ((state_q == RESP) && rsp_ready) begin
      // Data registers keep their last value once drained.
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      id_q     <= id_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_sum   = sum_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_signed_add_arbiter.sv
// Directed bench for signed_add_arbiter with a cycle-level reference model.
module tb_signed_add_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_sub;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic           rsp_ovf;
  logic [1:0]     rsp_id;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  // Reference model state
  logic         m_valid = 1'b0;
  logic [W-1:0] m_sum   = '0;
  logic         m_ovf   = 1'b0;
  int           m_id    = 0;
  int           m_ptr   = N - 1;
  int           m_pick;

  signed_add_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_ovf   (rsp_ovf),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int g;
    logic [N-1:0] r;
    r = '0;
    g = model_pick();
    if (g >= 0 && (!m_valid || rsp_ready)) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_exec(input int g);
    longint a, b, r;
    a = longint'($signed(req_a[g*W +: W]));
    b = longint'($signed(req_b[g*W +: W]));
    r = req_sub[g] ? (a - b) : (a + b);
    m_ovf = (r > MAXV) || (r < MINV);
    m_sum = r[W-1:0];
    m_id  = g;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_sum   = '0;
      m_ovf   = 1'b0;
      m_id    = 0;
      m_ptr   = N - 1;
    end else begin
      m_pick = model_pick();
      if (m_pick >= 0 && (!m_valid || rsp_ready)) begin
        model_exec(m_pick);
        m_valid = 1'b1;
        m_ptr   = m_pick;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("cyc_req_ready", req_ready, model_ready());
      check("cyc_rsp_valid", rsp_valid, m_valid);
      check("cyc_rsp_sum", rsp_sum, m_sum);
      check("cyc_rsp_ovf", rsp_ovf, m_ovf);
      check("cyc_rsp_id", rsp_id, m_id[1:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s);
    req_valid[i]       = v;
    req_a[i*W +: W]    = a;
    req_b[i*W +: W]    = b;
    req_sub[i]         = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [W-1:0] va [4] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'hFFFFFFFF};
  logic [W-1:0] vb [4] = '{32'h00000001, 32'h00000001, 32'h80000000, 32'hFFFFFFFF};
  logic         vs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [W-1:0] vr [4] = '{32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFE};
  logic         vo [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  int exp_ids [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int run, max_run, count2;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Reset state
    #1;
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_sum", rsp_sum, 32'h0);
    check("rst_ovf", rsp_ovf, 1'b0);
    check("rst_id", rsp_id, 2'd0);

    // Test 1: 5 + (-3)
    set_req(0, 1'b1, 32'd5, 32'hFFFFFFFD, 1'b0);
    #1;
    check("t1_ready", req_ready, 4'b0001);
    tick();
    check("t1_valid", rsp_valid, 1'b1);
    check("t1_sum", rsp_sum, 32'd2);
    check("t1_ovf", rsp_ovf, 1'b0);
    check("t1_id", rsp_id, 2'd0);
    set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    check("t1_drop", rsp_valid, 1'b0);

    // Test 2: overflow vectors, back to back on requester 0
    for (int v = 0; v < 4; v++) begin
      set_req(0, 1'b1, va[v], vb[v], vs[v]);
      tick();
      check("t2_sum", rsp_sum, vr[v]);
      check("t2_ovf", rsp_ovf, vo[v]);
    end
    set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();

    // Test 3: all requesters continuously valid after a fresh reset
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(i * 10), 32'(i), 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t3_valid", rsp_valid, 1'b1);
      check("t3_id", rsp_id, exp_ids[k][1:0]);
      check("t3_sum", rsp_sum, 32'(exp_ids[k] * 11));
    end
    req_valid = '0;
    tick();

    // Test 4: backpressure with req1 and req2 pending
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'd10, 32'd20, 1'b0);
    tick();
    set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
    set_req(1, 1'b1, 32'd100, 32'd1, 1'b1);
    set_req(2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_ready_blocked", req_ready, 4'b0000);
      tick();
      check("t4_hold_valid", rsp_valid, 1'b1);
      check("t4_hold_sum", rsp_sum, 32'd30);
      check("t4_hold_id", rsp_id, 2'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("t4_ready_req1", req_ready, 4'b0010);
    tick();
    check("t4_id1", rsp_id, 2'd1);
    check("t4_sum1", rsp_sum, 32'd99);
    set_req(1, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    check("t4_id2", rsp_id, 2'd2);
    check("t4_sum2", rsp_sum, 32'd0);
    req_valid = '0;
    tick();

    // Test 5: asynchronous reset while a result is held
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'd1, 32'd1, 1'b0);
    tick();
    check("t5_pre_valid", rsp_valid, 1'b1);
    set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_async_drop", rsp_valid, 1'b0);
    check("t5_async_sum", rsp_sum, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_req(1, 1'b1, 32'd7, 32'd3, 1'b1);
    set_req(3, 1'b1, 32'd7, 32'd3, 1'b0);
    tick();
    check("t5_id1", rsp_id, 2'd1);
    check("t5_sum1", rsp_sum, 32'd4);
    tick();
    check("t5_id3", rsp_id, 2'd3);
    check("t5_sum3", rsp_sum, 32'd10);
    req_valid = '0;
    tick();

    // Test 6: req2 held while req0 toggles
    set_req(2, 1'b1, 32'd2, 32'd2, 1'b0);
    set_req(0, 1'b0, 32'd1, 32'd1, 1'b0);
    run = 0;
    max_run = 0;
    count2 = 0;
    for (int k = 0; k < 12; k++) begin
      req_valid[0] = (k % 2 == 0);
      tick();
      if (rsp_valid) begin
        if (rsp_id == 2'd2) begin
          run = 0;
          count2++;
        end else begin
          run++;
          if (run > max_run) max_run = run;
        end
      end
    end
    check("t6_fair_gap", (max_run <= 1), 1'b1);
    check("t6_req2_grants", count2, 6);
    req_valid = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
